period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock or an external pulse train, in units of the system clock. It is the receiving-side counterpart of the clock divider: the divider turns a count into a waveform, and this block turns a waveform back into a count. It sits beside the dividers to self-check generated clocks and to feed measured rates to display/debug logic.

---
 rtl/period_meter.sv | 151 +++++++++++++++
 tb/tb_period_meter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow, asynchronous square wave in
// units of the system clock. sig_in passes through a three-flop synchronizer.
// Rising and falling edges are detected on the synchronized copy. A saturating
// counter runs between rising edges. The first rising edge only arms the
// meter. Each later rising edge publishes the edge-to-edge spacing
// (period) and the count captured at the falling edge (high_time).
//
// Ports:
//   clk_in     in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active low
//   sig_in     in   1      asynchronous waveform to measure
//   period     out  WIDTH  cycles between the last two rising edges
//   high_time  out  WIDTH  cycles sig_in was high within that period
//   valid      out  1      one-cycle pulse when period/high_time update
//   timeout    out  1      sticky: no rising edge within MAX_COUNT cycles
//   busy       out  1      high while a measurement is in progress
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int unsigned      WIDTH     = 31,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_sh_q, hi_sh_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             at_max;

  // Synchronizer. s1 may go metastable; edges are taken from s2/s3 only.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;
  assign at_max = (cnt_q == MAX_COUNT);

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic. A rise at the saturation point wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!rise && at_max) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_MEASURE);
  end

  // Measurement datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    hi_sh_d   = hi_sh_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (rise) begin
      // cnt already holds the edge-to-edge spacing; restart at 1 so the
      // next publish again equals the spacing.
      cnt_d   = WIDTH'(1);
      hi_sh_d = '0;  // no fall before the next rise means high_time = 0
      if (state_q == ST_MEASURE) begin
        period_d  = cnt_q;
        high_d    = hi_sh_q;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else if (state_q == ST_MEASURE) begin
      if (at_max) begin
        timeout_d = 1'b1;       // counter saturates; it does not wrap
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      if (fall) hi_sh_d = cnt_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q     <= '0;
      hi_sh_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_sh_q   <= hi_sh_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Testbench for period_meter with MAX_COUNT = 20.
// A reference model works on edge numbers. It records the value of sig_in
// seen at every clock edge. A rising edge acts two edges after it is
// sampled. The model then derives period, high time and timeout from the
// distances between edges. The outputs are compared on every falling clock
// edge. Literal checks at the end of each stimulus phase fix the model's
// expected numbers.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int unsigned WIDTH = 31;
  localparam int          MAXC  = 20;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b0;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;
  int dut_valid_cnt = 0;

  period_meter #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(WIDTH'(MAXC))
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (edge-number arithmetic) ----------------
  bit     samp[$];
  int     edge_n    = 0;
  int     last_rst  = 0;
  bit     armed     = 0;
  int     rise_e    = 0;
  int     fall_e    = 0;
  bit     fall_seen = 0;
  bit     model_live = 0;
  longint m_period = 0, m_high = 0;
  bit     m_valid = 0, m_timeout = 0;

  // Value of sig_in taken at edge k. Samples taken at or before a reset edge
  // never reach the edge detector.
  function automatic bit smp(int k);
    if (k <= last_rst || k < 0) return 1'b0;
    return samp[k];
  endfunction

  always @(posedge clk_in) begin
    bit r, f;
    samp.push_back(sig_in);
    if (!rst) begin
      last_rst   = edge_n;
      armed      = 0;
      fall_seen  = 0;
      m_period   = 0;
      m_high     = 0;
      m_valid    = 0;
      m_timeout  = 0;
      model_live = 1;
    end else begin
      // An edge sampled at edge k is acted on at edge k+2.
      r = smp(edge_n - 2) && !smp(edge_n - 3);
      f = !smp(edge_n - 2) && smp(edge_n - 3);
      m_valid = 0;
      if (r) begin
        if (armed) begin
          m_period  = edge_n - rise_e;
          m_high    = fall_seen ? (fall_e - rise_e) : 0;
          m_valid   = 1;
          m_timeout = 0;
        end
        armed     = 1;
        rise_e    = edge_n;
        fall_seen = 0;
      end else if (armed && (edge_n - rise_e) == MAXC) begin
        m_timeout = 1;
        armed     = 0;
      end else if (armed && f) begin
        fall_seen = 1;
        fall_e    = edge_n;
      end
    end
    edge_n++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    if (model_live) begin
      chk("period",    period,    m_period);
      chk("high_time", high_time, m_high);
      chk("valid",     valid,     m_valid);
      chk("timeout",   timeout,   m_timeout);
      chk("busy",      busy,      armed);
      if (valid) dut_valid_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      sig_in = b;
    end
  endtask

  task automatic pulses(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  int v0;

  initial begin
    // Reset
    rst = 1'b0;
    drive(1'b0, 3);
    chk("reset_period", period, 0);
    chk("reset_busy",   busy,   0);
    rst = 1'b1;
    drive(1'b0, 4);

    // Divider waveform, toggling every 5 cycles
    v0 = dut_valid_cnt;
    pulses(5, 5, 6);
    chk("div_valid_count", dut_valid_cnt - v0, 5);
    chk("div_period",      period,    10);
    chk("div_high",        high_time, 5);

    // 3 high / 7 low
    v0 = dut_valid_cnt;
    pulses(3, 7, 5);
    chk("p37_valid_count", dut_valid_cnt - v0, 5);
    chk("p37_period",      period,    10);
    chk("p37_high",        high_time, 3);
    chk("p37_timeout",     timeout,   0);

    // Stop toggling: timeout, then re-arm and measure
    drive(1'b0, 30);
    chk("to_timeout", timeout,   1);
    chk("to_busy",    busy,      0);
    chk("to_period",  period,    10);
    chk("to_high",    high_time, 3);
    v0 = dut_valid_cnt;
    pulses(4, 11, 1);
    chk("rearm_no_valid", dut_valid_cnt - v0, 0);
    chk("rearm_timeout",  timeout, 1);
    drive(1'b1, 4);
    drive(1'b0, 5);
    chk("rearm_period",  period,    15);
    chk("rearm_high",    high_time, 4);
    chk("rearm_timeout_cleared", timeout, 0);

    // Rise spacing exactly MAX_COUNT
    pulses(6, 14, 3);
    drive(1'b1, 6);
    drive(1'b0, 5);
    chk("max_period",  period,    20);
    chk("max_high",    high_time, 6);
    chk("max_timeout", timeout,   0);
    drive(1'b0, 30);

    // Reset mid-period
    pulses(3, 7, 3);
    drive(1'b1, 3);
    drive(1'b0, 3);
    rst = 1'b0;
    @(negedge clk_in);
    rst = 1'b1;
    chk("mrst_period",  period,    0);
    chk("mrst_high",    high_time, 0);
    chk("mrst_valid",   valid,     0);
    chk("mrst_timeout", timeout,   0);
    chk("mrst_busy",    busy,      0);
    v0 = dut_valid_cnt;
    drive(1'b0, 4);
    pulses(3, 7, 1);
    chk("mrst_first_rise_no_valid", dut_valid_cnt - v0, 0);
    pulses(3, 7, 1);
    chk("mrst_second_rise_valid", dut_valid_cnt - v0, 1);
    chk("mrst_period2", period, 10);

    // Held high from reset with narrow, unsampled low glitches
    rst = 1'b0;
    drive(1'b1, 2);
    rst = 1'b1;
    v0 = dut_valid_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (i % 12 == 11) begin
        sig_in = 1'b0;
        #2;
        sig_in = 1'b1;
      end
    end
    chk("glitch_no_valid", dut_valid_cnt - v0, 0);
    chk("glitch_timeout",  timeout, 1);
    chk("glitch_busy",     busy,    0);
    chk("glitch_period",   period,  0);

    // Randomized periods, some longer than MAX_COUNT
    drive(1'b0, 5);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, $urandom_range(1, 12));
      drive(1'b0, $urandom_range(1, 12));
    end

    // Minimum period: toggle every cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 2);
    chk("min_period", period,    2);
    chk("min_high",   high_time, 1);

    // Random bits per cycle with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      sig_in = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
    end
    @(negedge clk_in);
    rst = 1'b1;
    drive(1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
